// File: rtl/ahb_pkg.sv
// Shared types for the AHB arbiter: transfer encoding, arbiter FSM states and
// a one-hot to index helper used by the RTL and the bench.
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [1:0] {
    PARK    = 2'b00,
    GRANTED = 2'b01,
    LOCKED  = 2'b10
  } arb_state_e;

  localparam int MAX_MASTERS = 16;

  // OR-encoder: correct for any one-hot input, returns 0 for an all-zero one.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_MASTERS-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Bus-side signals of the arbiter plus debug visibility of its FSM state and
// beat counter. The master modport is the requester/bus side, slave is the arbiter.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS     = 4,
  parameter int MAX_BURST_BEATS = 16
);
  import ahb_pkg::*;

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int BEAT_W = $clog2(MAX_BURST_BEATS + 1);

  // Handshake: a master holds HBUSREQ until it sees its HGRANT bit; every
  // arbiter output advances only on a clock edge where HREADY is high.
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  htrans_e                HTRANS;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [IDX_W-1:0]       HMASTER;
  logic                   HMASTLOCK;
  arb_state_e             state;
  logic [BEAT_W-1:0]      beat_cnt;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HREADY,
    input  HGRANT, HMASTER, HMASTLOCK, state, beat_cnt
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HREADY,
    output HGRANT, HMASTER, HMASTLOCK, state, beat_cnt
  );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: searches upward from rr_ptr+1 with wrap,
// so the master at rr_ptr itself is considered last.
module ahb_rr_picker #(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0]         req,
  input  logic [$clog2(NUM_MASTERS)-1:0] rr_ptr,
  output logic [NUM_MASTERS-1:0]         winner,
  output logic                           valid
);
  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [IDX_W-1:0] cand;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = rr_ptr;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (!valid && req[cand]) begin
        winner[cand] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter with bus parking, locked-transfer hold and burst
// preemption after MAX_BURST_BEATS active beats.
module ahb_arbiter #(
  parameter int NUM_MASTERS     = 4,
  parameter int DEFAULT_MASTER  = 0,
  parameter int MAX_BURST_BEATS = 16
) (
  input logic          HCLK,
  input logic          HRESET,
  ahb_arbiter_if.slave bus
);
  import ahb_pkg::*;

  localparam int IDX_W  = $clog2(NUM_MASTERS);
  localparam int BEAT_W = $clog2(MAX_BURST_BEATS + 1);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [IDX_W-1:0]       DEFAULT_IDX = IDX_W'(DEFAULT_MASTER);
  localparam logic [BEAT_W-1:0]      BEAT_MAX    = BEAT_W'(MAX_BURST_BEATS);

  arb_state_e             state_q;
  logic [NUM_MASTERS-1:0] grant_q;
  logic [IDX_W-1:0]       hmaster_q;
  logic                   hmastlock_q;
  logic [IDX_W-1:0]       rr_ptr_q;
  logic [BEAT_W-1:0]      beat_q;
  logic                   armed_q;

  logic [NUM_MASTERS-1:0] all_oh, oth_oh, rearb_grant;
  logic                   all_valid, oth_valid;
  logic [IDX_W-1:0]       owner_idx, all_idx, rearb_idx;
  arb_state_e             rearb_state;
  logic                   owner_req, owner_lock, active, preempt, lock_release, rearb_chg;

  ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick_all (
    .req    (bus.HBUSREQ),
    .rr_ptr (rr_ptr_q),
    .winner (all_oh),
    .valid  (all_valid)
  );

  // The owner is masked out so a preempted or releasing owner cannot re-win.
  ahb_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_pick_oth (
    .req    (bus.HBUSREQ & ~grant_q),
    .rr_ptr (rr_ptr_q),
    .winner (oth_oh),
    .valid  (oth_valid)
  );

  assign owner_idx    = IDX_W'(onehot_to_idx(MAX_MASTERS'(grant_q)));
  assign all_idx      = IDX_W'(onehot_to_idx(MAX_MASTERS'(all_oh)));
  assign rearb_idx    = IDX_W'(onehot_to_idx(MAX_MASTERS'(rearb_grant)));
  assign owner_req    = |(bus.HBUSREQ & grant_q);
  assign owner_lock   = |(bus.HLOCK & grant_q);
  assign active       = (bus.HTRANS == NONSEQ) || (bus.HTRANS == SEQ);
  assign preempt      = (beat_q == BEAT_MAX) && oth_valid;
  assign lock_release = armed_q && !owner_lock && (bus.HTRANS == IDLE);
  assign rearb_chg    = (rearb_grant != grant_q);

  always_comb begin
    rearb_grant = DEFAULT_OH;
    rearb_state = PARK;
    if (oth_valid) begin
      rearb_grant = oth_oh;
      rearb_state = GRANTED;
    end else if (owner_req) begin
      rearb_grant = grant_q;
      rearb_state = GRANTED;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= PARK;
      grant_q     <= DEFAULT_OH;
      hmaster_q   <= DEFAULT_IDX;
      hmastlock_q <= 1'b0;
      rr_ptr_q    <= DEFAULT_IDX;
      beat_q      <= '0;
      armed_q     <= 1'b0;
    end else if (bus.HREADY) begin
      hmaster_q   <= owner_idx;
      hmastlock_q <= owner_lock;
      // armed_q: the owner's HLOCK was low on the previous HREADY cycle.
      armed_q     <= (state_q == LOCKED) && !owner_lock;
      if (active && beat_q != BEAT_MAX) beat_q <= beat_q + 1'b1;
      case (state_q)
        PARK: begin
          if (all_valid) begin
            state_q <= GRANTED;
            if (all_oh != grant_q) begin
              grant_q  <= all_oh;
              rr_ptr_q <= all_idx;
              beat_q   <= '0;
            end
          end
        end
        GRANTED: begin
          if (owner_lock) begin
            state_q <= LOCKED;
          end else if (!owner_req || preempt) begin
            state_q <= rearb_state;
            if (rearb_chg) begin
              grant_q  <= rearb_grant;
              rr_ptr_q <= rearb_idx;
              beat_q   <= '0;
            end
          end
        end
        LOCKED: begin
          if (lock_release) begin
            state_q <= rearb_state;
            if (rearb_chg) begin
              grant_q  <= rearb_grant;
              rr_ptr_q <= rearb_idx;
              beat_q   <= '0;
            end
          end
        end
        default: state_q <= PARK;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET) assert ($onehot(grant_q));
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;
  assign bus.state     = state_q;
  assign bus.beat_cnt  = beat_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed plus randomized bench for ahb_arbiter, checked every cycle against
// an index-based reference model and a queue of expected grant changes.
module tb_ahb_arbiter;
  import ahb_pkg::*;

  localparam int NM   = 4;
  localparam int DEF  = 0;
  localparam int MAXB = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  ahb_arbiter_if #(.NUM_MASTERS(NM), .MAX_BURST_BEATS(MAXB)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS     (NM),
    .DEFAULT_MASTER  (DEF),
    .MAX_BURST_BEATS (MAXB)
  ) dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus)
  );

  // scoreboard
  int              n_tests = 0;
  int              n_fail  = 0;
  logic [NM-1:0]   exp_q[$];
  logic [NM-1:0]   last_grant = '0;
  bit              track = 1'b0;

  // reference model
  int         m_owner = DEF;
  int         m_hmaster = DEF;
  int         m_rr = DEF;
  int         m_beats = 0;
  bit         m_lock = 1'b0;
  bit         m_armed = 1'b0;
  arb_state_e m_state = PARK;

  function automatic bit bit_of(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  function automatic int rr_pick(input logic [NM-1:0] req, input int after);
    for (int k = 1; k <= NM; k++) begin
      if (bit_of(req, (after + k) % NM)) return (after + k) % NM;
    end
    return -1;
  endfunction

  task automatic model_step();
    logic [NM-1:0] req, lk, others;
    int nxt, w;
    arb_state_e ns;
    bit rearb;
    if (rst) begin
      m_owner = DEF; m_hmaster = DEF; m_lock = 1'b0; m_state = PARK;
      m_rr = DEF; m_beats = 0; m_armed = 1'b0;
      return;
    end
    if (!bus.HREADY) return;
    req    = bus.HBUSREQ;
    lk     = bus.HLOCK;
    others = req & ~(NM'(1) << m_owner);
    nxt    = m_owner;
    ns     = m_state;
    rearb  = 1'b0;
    case (m_state)
      PARK: begin
        w = rr_pick(req, m_rr);
        if (w >= 0) begin nxt = w; ns = GRANTED; end
      end
      GRANTED: begin
        if (bit_of(lk, m_owner)) ns = LOCKED;
        else if (!bit_of(req, m_owner) || (m_beats == MAXB && others != '0)) rearb = 1'b1;
      end
      default: begin
        if (m_armed && !bit_of(lk, m_owner) && bus.HTRANS == IDLE) rearb = 1'b1;
      end
    endcase
    if (rearb) begin
      w = rr_pick(others, m_rr);
      if (w >= 0) begin nxt = w; ns = GRANTED; end
      else if (bit_of(req, m_owner)) ns = GRANTED;
      else begin nxt = DEF; ns = PARK; end
    end
    m_armed   = (m_state == LOCKED) && !bit_of(lk, m_owner);
    m_hmaster = m_owner;
    m_lock    = bit_of(lk, m_owner);
    if (nxt != m_owner) begin
      m_beats = 0;
      m_rr    = nxt;
    end else if (bus.HTRANS == NONSEQ || bus.HTRANS == SEQ) begin
      m_beats = (m_beats < MAXB) ? m_beats + 1 : MAXB;
    end
    m_owner = nxt;
    m_state = ns;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [NM-1:0] req, input logic [NM-1:0] lk,
                       input htrans_e tr, input logic rdy);
    bus.HBUSREQ = req;
    bus.HLOCK   = lk;
    bus.HTRANS  = tr;
    bus.HREADY  = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("hgrant",    32'(bus.HGRANT),    32'(NM'(1) << m_owner));
    check("hmaster",   32'(bus.HMASTER),   32'(m_hmaster));
    check("hmastlock", 32'(bus.HMASTLOCK), 32'(m_lock));
    check("state",     32'(bus.state),     32'(m_state));
    check("beat_cnt",  32'(bus.beat_cnt),  32'(m_beats));
    if (track && bus.HGRANT !== last_grant) begin
      if (exp_q.size() == 0) check("grant_seq_unexpected", 32'(bus.HGRANT), 32'(last_grant));
      else check("grant_seq", 32'(bus.HGRANT), 32'(exp_q.pop_front()));
    end
    last_grant = bus.HGRANT;
  endtask

  initial begin
    logic [NM-1:0] rq, lk;
    htrans_e tr;
    int own, len;

    // reset, then idle bus parks on the default master
    drive('0, '0, IDLE, 1'b1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("park_grant",     32'(bus.HGRANT),    32'h1);
      check("park_hmaster",   32'(bus.HMASTER),   32'h0);
      check("park_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
    end

    // round robin across masters 1..3 with request drops
    track = 1'b1;
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0010);
    drive(4'b1110, '0, IDLE, 1'b1);
    tick();
    for (int r = 0; r < 3; r++) begin
      own = m_owner;
      tick();
      drive(4'b1110, '0, NONSEQ, 1'b1);
      tick();
      tick();
      drive(4'b1110, '0, IDLE, 1'b1);
      tick();
      drive(4'b1110 & ~(NM'(1) << own), '0, IDLE, 1'b1);
      tick();
      drive(4'b1110, '0, IDLE, 1'b1);
    end
    check("rr_seq_drained", 32'(exp_q.size()), 32'h0);

    // burst preemption after MAXB beats
    exp_q.push_back(4'b0100);
    drive(4'b0110, '0, NONSEQ, 1'b1);
    tick();
    drive(4'b0110, '0, SEQ, 1'b1);
    for (int i = 0; i < 19; i++) tick();
    check("preempt_drained", 32'(exp_q.size()), 32'h0);

    // locked burst holds grant against other requesters
    exp_q.push_back(4'b1000);
    drive(4'b1000, 4'b1000, IDLE, 1'b1);
    tick();
    tick();
    drive(4'b1011, 4'b1000, NONSEQ, 1'b1);
    tick();
    drive(4'b1011, 4'b1000, SEQ, 1'b1);
    for (int i = 0; i < 19; i++) begin
      tick();
      check("lock_grant",     32'(bus.HGRANT),    32'h8);
      check("lock_hmastlock", 32'(bus.HMASTLOCK), 32'h1);
    end
    exp_q.push_back(4'b0001);
    drive(4'b1011, '0, IDLE, 1'b1);
    tick();
    tick();
    drive(4'b0011, '0, IDLE, 1'b1);
    check("unlock_drained", 32'(exp_q.size()), 32'h0);

    // HREADY low freezes a pending handover
    drive(4'b0011, '0, NONSEQ, 1'b1);
    tick();
    tick();
    exp_q.push_back(4'b0010);
    drive(4'b0010, '0, NONSEQ, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("freeze_grant", 32'(bus.HGRANT),   32'h1);
      check("freeze_beats", 32'(bus.beat_cnt), 32'h2);
    end
    drive(4'b0010, '0, IDLE, 1'b1);
    tick();
    tick();
    check("handover_hmaster", 32'(bus.HMASTER), 32'h1);
    check("freeze_drained",   32'(exp_q.size()), 32'h0);

    // reset in the middle of a locked burst
    exp_q.push_back(4'b0100);
    drive(4'b0100, 4'b0100, IDLE, 1'b1);
    tick();
    tick();
    drive(4'b0100, 4'b0100, SEQ, 1'b1);
    tick();
    tick();
    tick();
    check("lock2_drained", 32'(exp_q.size()), 32'h0);
    track = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_grant",     32'(bus.HGRANT),    32'h1);
    check("rst_hmaster",   32'(bus.HMASTER),   32'h0);
    check("rst_hmastlock", 32'(bus.HMASTLOCK), 32'h0);
    check("rst_state",     32'(bus.state),     32'(PARK));
    rst = 1'b0;
    drive('0, '0, IDLE, 1'b1);
    tick();

    // randomized segments against the reference model
    for (int s = 0; s < 40; s++) begin
      rq  = NM'($urandom_range(0, (1 << NM) - 1));
      lk  = ($urandom_range(0, 2) == 0) ? (NM'(1) << $urandom_range(0, NM - 1)) : '0;
      len = $urandom_range(1, 24);
      for (int c = 0; c < len; c++) begin
        tr = ($urandom_range(0, 3) != 0) ? SEQ : htrans_e'($urandom_range(0, 3));
        drive(rq, lk, tr, ($urandom_range(0, 4) != 0));
        rst = ($urandom_range(0, 199) == 0);
        tick();
      end
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
